dma_protocol_monitor: RTL and testbench
=======================================

// Module: dma_protocol_monitor
// PURPOSE
//  Synthesisable run-time protocol monitor for the DMA controller, parametrised in channel count.
//  Sits beside the controller and samples the bus (CS_N, HLDA, HRQ, DREQ, DACK) and the
//  timing-and-control one-hot state. Checks state sequencing, DACK encoding, request latency and
//  fixed/rotating priority. Reports sticky error flags plus saturating error and grant counters.
// PARAMETERS
//  NUM_CH   4   number of DMA channels (>=2); CH_W = $clog2(NUM_CH) derived
//  MAX_LAT  16  max cycles a pending DREQ may wait for its DACK while HLDA=1 (>=2)
//  CNT_W    16  width of ERR_CNT and GRANT_CNT
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  RESET_N    in   1       asynchronous active-low reset
//  CS_N       in   1       chip select; monitor checks only when 0
//  HLDA       in   1       hold acknowledge from CPU
//  HRQ        in   1       hold request from controller
//  DREQ       in   NUM_CH  channel requests
//  DACK       in   NUM_CH  channel acknowledges
//  STATE      in   6       controller state: SI=000001 S0=000010 S1=000100 S2=001000 S3=010000 S4=100000
//  ROT_PRIO   in   1       0 = fixed priority (ch0 highest), 1 = rotating priority
//  CLR_ERR    in   1       synchronous clear of ERR_FLAGS and ERR_CNT
//  ERR_FLAGS  out  5       sticky: [0] DACK not one-hot0, [1] latency timeout, [2] priority/unrequested grant,
//                          [3] illegal STATE value or transition, [4] DACK!=0 while HLDA=0
//  ERR_CNT    out  CNT_W   saturating count of cycles with >=1 new error event
//  GRANT_CNT  out  CNT_W   saturating count of grants
//  LAST_CH    out  CH_W    index of last granted channel
//  BUSY       out  1       registered: previous-cycle STATE != SI
// BEHAVIOUR
//  - Reset (RESET_N=0, async): all outputs 0; prev-state reg = SI; DREQ_q/DACK_q = 0; latency counters 0; rot ptr 0.
//  - All outputs registered; each error is visible on ERR_FLAGS one cycle after the offending sample.
//  - CS_N=1: no error events, latency counters held at 0, grants not counted; prev-state still tracks STATE.
//  - Legal transitions (prev->cur): SI->SI, SI->S0, S0->S0, S0->S1, S1->S2, S2->S3, S2->S4, S3->S4, S4->S1, S4->SI.
//    Any other pair, or STATE not one-hot -> err[3]. Non-one-hot value stored as prev; next check compares to it.
//  - err[0]: DACK has >1 bit set in a cycle.
//  - err[4]: DACK != 0 while HLDA == 0.
//  - Grant = cycle where DACK_q == 0 and DACK is one-hot; GRANT_CNT += 1 (saturate), LAST_CH <= granted index.
//  - err[2] on grant: DREQ_q == 0, or granted ch != highest-priority set bit of DREQ_q.
//    Fixed: priority ch0 > ch1 > ... Rotating: search starts at ptr; on grant to k, ptr <= (k+1) mod NUM_CH.
//    ROT_PRIO=0 forces ptr to 0; mode change takes effect on next grant check.
//  - Latency counter per channel, width $clog2(MAX_LAT+1): cleared when DREQ[i]=0 or DACK[i]=1;
//    increments when DREQ[i]=1, DACK[i]=0, HLDA=1; holds when HLDA=0. On 0->MAX_LAT step (reaching MAX_LAT)
//    one err[1] event fires; counter then saturates at MAX_LAT, no repeat until cleared.
//  - Simultaneous errors in one cycle: all flag bits set, ERR_CNT +1 only.
//  - CLR_ERR=1: flags <= new events of this cycle, ERR_CNT <= (any new event ? 1 : 0). GRANT_CNT unaffected.
//  - ERR_CNT, GRANT_CNT saturate at 2**CNT_W-1, never wrap.
//  - Reset mid-transfer: all state dropped immediately; first post-reset STATE compared against SI.
// TESTING
//  1 Sequence SI,S0,S1,S2,S4,SI with CS_N=0,HLDA=1 -> ERR_FLAGS=0, BUSY=1 from cycle after S0 until cycle after SI.
//  2 STATE SI->S2 directly -> ERR_FLAGS=5'b01000, ERR_CNT=1 next cycle; CLR_ERR pulse -> both 0.
//  3 Fixed prio, DREQ=4'b0110, then DACK=4'b0100 -> err[2]; repeat with DACK=4'b0010 -> no error, LAST_CH=1.
//  4 Rotating, grant ch2 then DREQ=4'b1001, DACK=4'b1000 -> no error; DACK=4'b0001 instead -> err[2].
//  5 DREQ[3]=1, HLDA=1, DACK=0 for 16 cycles -> err[1] once, ERR_CNT=1; hold 10 more cycles -> ERR_CNT stays 1.
//  6 DACK=4'b0011 with HLDA=0 in same cycle -> ERR_FLAGS=5'b10001, ERR_CNT +1; RESET_N low mid-op -> all outputs 0.

Source files
------------

// File: rtl/dma_protocol_monitor.sv
// Run-time protocol monitor for the DMA controller: watches bus handshakes and the
// timing-and-control state, raising sticky error flags and keeping error/grant counters.
module dma_protocol_monitor #(
   parameter int NUM_CH  = 4,
   parameter int MAX_LAT = 16,
   parameter int CNT_W   = 16,
   localparam int CH_W   = $clog2(NUM_CH),
   localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cs_n_i,
   input  logic              hlda_i,
   input  logic              hrq_i,
   input  logic [NUM_CH-1:0] dreq_i,
   input  logic [NUM_CH-1:0] dack_i,
   input  logic [5:0]        state_i,
   input  logic              rot_prio_i,
   input  logic              clr_err_i,
   output logic [4:0]        err_flags_o,
   output logic [CNT_W-1:0]  err_cnt_o,
   output logic [CNT_W-1:0]  grant_cnt_o,
   output logic [CH_W-1:0]   last_ch_o,
   output logic              busy_o
);

   localparam logic [5:0] SI = 6'b000001;
   localparam logic [5:0] S0 = 6'b000010;
   localparam logic [5:0] S1 = 6'b000100;
   localparam logic [5:0] S2 = 6'b001000;
   localparam logic [5:0] S3 = 6'b010000;
   localparam logic [5:0] S4 = 6'b100000;

   logic [5:0]        prevState_q, prevState_d;
   logic [NUM_CH-1:0] dreq_q, dack_q;
   logic [LAT_W-1:0]  latCnt_q [NUM_CH];
   logic [LAT_W-1:0]  latCnt_d [NUM_CH];
   logic [CH_W-1:0]   rotPtr_q, rotPtr_d;
   logic [CH_W-1:0]   lastCh_q, lastCh_d;
   logic [4:0]        flags_q, flags_d;
   logic [CNT_W-1:0]  errCnt_q, errCnt_d;
   logic [CNT_W-1:0]  grantCnt_q, grantCnt_d;
   logic              busy_q, busy_d;

   logic              active;
   logic              legalStep;
   logic              grant;
   logic [CH_W-1:0]   grantIdx;
   logic [CH_W-1:0]   startPtr;
   logic [CH_W-1:0]   winner;
   logic [CH_W-1:0]   searchBit;
   logic              found;
   int                searchIdx;
   logic [NUM_CH-1:0] latEv;
   logic [4:0]        newEv;
   logic              anyEv;

   // HRQ is sampled for completeness of the bus view but no rule depends on it yet
   logic              unusedHrq;
   assign unusedHrq = hrq_i;

   assign active = ~cs_n_i;

   // Legal step table; a non-one-hot previous value matches no row and so always flags
   always_comb begin
      legalStep = 1'b0;
      case (prevState_q)
         SI:      legalStep = (state_i == SI) || (state_i == S0);
         S0:      legalStep = (state_i == S0) || (state_i == S1);
         S1:      legalStep = (state_i == S2);
         S2:      legalStep = (state_i == S3) || (state_i == S4);
         S3:      legalStep = (state_i == S4);
         S4:      legalStep = (state_i == S1) || (state_i == SI);
         default: legalStep = 1'b0;
      endcase
   end

   // Grant detection and the expected winner from the previous cycle's requests
   always_comb begin
      grantIdx  = '0;
      winner    = '0;
      found     = 1'b0;
      searchIdx = 0;
      searchBit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (dack_i[i]) grantIdx = CH_W'(i);
      end
      startPtr = rot_prio_i ? rotPtr_q : '0;
      for (int off = 0; off < NUM_CH; off++) begin
         searchIdx = int'(startPtr) + off;
         if (searchIdx >= NUM_CH) searchIdx = searchIdx - NUM_CH;
         searchBit = CH_W'(searchIdx);
         if (!found && dreq_q[searchBit]) begin
            found  = 1'b1;
            winner = searchBit;
         end
      end
      grant = active && (dack_q == '0) && $onehot(dack_i);
   end

   // Per-channel wait counters fire exactly once when they first reach MAX_LAT
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         latEv[i]    = 1'b0;
         latCnt_d[i] = latCnt_q[i];
         if (!active || !dreq_i[i] || dack_i[i]) begin
            latCnt_d[i] = '0;
         end else if (hlda_i && (latCnt_q[i] != LAT_W'(MAX_LAT))) begin
            latCnt_d[i] = latCnt_q[i] + 1'b1;
            if (latCnt_q[i] == LAT_W'(MAX_LAT - 1)) latEv[i] = 1'b1;
         end
      end
   end

   always_comb begin
      newEv    = '0;
      newEv[0] = active && ($countones(dack_i) > 1);
      newEv[1] = |latEv;
      newEv[2] = grant && (!found || (winner != grantIdx));
      newEv[3] = active && (!$onehot(state_i) || !legalStep);
      newEv[4] = active && (dack_i != '0) && !hlda_i;
      anyEv    = |newEv;
   end

   // Error flags and counters; a clear still captures events of the clearing cycle
   always_comb begin
      flags_d    = flags_q | newEv;
      errCnt_d   = errCnt_q;
      grantCnt_d = grantCnt_q;
      lastCh_d   = lastCh_q;
      rotPtr_d   = rotPtr_q;
      if (clr_err_i) begin
         flags_d  = newEv;
         errCnt_d = {{(CNT_W-1){1'b0}}, anyEv};
      end else if (anyEv && (errCnt_q != '1)) begin
         errCnt_d = errCnt_q + 1'b1;
      end
      if (grant) begin
         lastCh_d = grantIdx;
         if (grantCnt_q != '1) grantCnt_d = grantCnt_q + 1'b1;
      end
      if (!rot_prio_i) begin
         rotPtr_d = '0;
      end else if (grant) begin
         rotPtr_d = (grantIdx == CH_W'(NUM_CH - 1)) ? '0 : grantIdx + 1'b1;
      end
      prevState_d = state_i;
      busy_d      = (state_i != SI);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prevState_q <= SI;
         dreq_q      <= '0;
         dack_q      <= '0;
         rotPtr_q    <= '0;
         lastCh_q    <= '0;
         flags_q     <= '0;
         errCnt_q    <= '0;
         grantCnt_q  <= '0;
         busy_q      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) latCnt_q[i] <= '0;
      end else begin
         prevState_q <= prevState_d;
         dreq_q      <= dreq_i;
         dack_q      <= dack_i;
         rotPtr_q    <= rotPtr_d;
         lastCh_q    <= lastCh_d;
         flags_q     <= flags_d;
         errCnt_q    <= errCnt_d;
         grantCnt_q  <= grantCnt_d;
         busy_q      <= busy_d;
         for (int i = 0; i < NUM_CH; i++) latCnt_q[i] <= latCnt_d[i];
      end
   end

   assign err_flags_o = flags_q;
   assign err_cnt_o   = errCnt_q;
   assign grant_cnt_o = grantCnt_q;
   assign last_ch_o   = lastCh_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_dma_protocol_monitor.sv
// Directed self-checking bench for dma_protocol_monitor with hand-computed expectations
// covering sequencing, priority, latency timeout, clear and reset behaviour.
module tb_dma_protocol_monitor;

   localparam logic [5:0] SI = 6'b000001;
   localparam logic [5:0] S0 = 6'b000010;
   localparam logic [5:0] S1 = 6'b000100;
   localparam logic [5:0] S2 = 6'b001000;
   localparam logic [5:0] S3 = 6'b010000;
   localparam logic [5:0] S4 = 6'b100000;

   logic        clock;
   logic        rstN;
   logic        csN;
   logic        hlda;
   logic        hrq;
   logic [3:0]  dreq;
   logic [3:0]  dack;
   logic [5:0]  state;
   logic        rotPrio;
   logic        clrErr;
   logic [4:0]  errFlags;
   logic [15:0] errCnt;
   logic [15:0] grantCnt;
   logic [1:0]  lastCh;
   logic        busy;

   int checkCount = 0;
   int errorCount = 0;

   dma_protocol_monitor dut (
      .clk_i       (clock),
      .rst_n_i     (rstN),
      .cs_n_i      (csN),
      .hlda_i      (hlda),
      .hrq_i       (hrq),
      .dreq_i      (dreq),
      .dack_i      (dack),
      .state_i     (state),
      .rot_prio_i  (rotPrio),
      .clr_err_i   (clrErr),
      .err_flags_o (errFlags),
      .err_cnt_o   (errCnt),
      .grant_cnt_o (grantCnt),
      .last_ch_o   (lastCh),
      .busy_o      (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Guard against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of bus values, then sample 1 time unit after the rising edge
   task automatic applyStimulus(input logic [5:0] st, input logic [3:0] rq, input logic [3:0] ak);
      state = st;
      dreq  = rq;
      dack  = ak;
      @(posedge clock);
      #1;
   endtask

   task automatic pulseClear();
      clrErr = 1'b1;
      applyStimulus(SI, 4'b0000, 4'b0000);
      clrErr = 1'b0;
   endtask

   initial begin
      rstN    = 1'b0;
      csN     = 1'b0;
      hlda    = 1'b1;
      hrq     = 1'b1;
      dreq    = '0;
      dack    = '0;
      state   = SI;
      rotPrio = 1'b0;
      clrErr  = 1'b0;
      #3;
      checkOutput("resetFlags", 32'(errFlags), 32'h0);
      checkOutput("resetErrCnt", 32'(errCnt), 32'h0);
      checkOutput("resetGrantCnt", 32'(grantCnt), 32'h0);
      checkOutput("resetLastCh", 32'(lastCh), 32'h0);
      checkOutput("resetBusy", 32'(busy), 32'h0);
      #9 rstN = 1'b1;

      // Legal walk SI,S0,S1,S2,S4,SI
      applyStimulus(SI, 4'b0000, 4'b0000);
      checkOutput("seqBusyIdle", 32'(busy), 32'h0);
      applyStimulus(S0, 4'b0000, 4'b0000);
      checkOutput("seqBusyS0", 32'(busy), 32'h1);
      applyStimulus(S1, 4'b0000, 4'b0000);
      applyStimulus(S2, 4'b0000, 4'b0000);
      applyStimulus(S4, 4'b0000, 4'b0000);
      checkOutput("seqBusyS4", 32'(busy), 32'h1);
      applyStimulus(SI, 4'b0000, 4'b0000);
      checkOutput("seqBusyBackIdle", 32'(busy), 32'h0);
      checkOutput("seqFlags", 32'(errFlags), 32'h0);

      // Illegal jump SI->S2, then clear while stepping legally S2->S3
      applyStimulus(S2, 4'b0000, 4'b0000);
      checkOutput("jumpFlags", 32'(errFlags), 32'h08);
      checkOutput("jumpErrCnt", 32'(errCnt), 32'h1);
      clrErr = 1'b1;
      applyStimulus(S3, 4'b0000, 4'b0000);
      clrErr = 1'b0;
      checkOutput("jumpClrFlags", 32'(errFlags), 32'h0);
      checkOutput("jumpClrErrCnt", 32'(errCnt), 32'h0);
      applyStimulus(S4, 4'b0000, 4'b0000);
      applyStimulus(SI, 4'b0000, 4'b0000);
      checkOutput("returnIdleFlags", 32'(errFlags), 32'h0);

      // Fixed priority: ch1 outranks ch2
      applyStimulus(SI, 4'b0110, 4'b0000);
      applyStimulus(SI, 4'b0110, 4'b0100);
      checkOutput("fixedBadFlags", 32'(errFlags), 32'h04);
      checkOutput("fixedBadGrantCnt", 32'(grantCnt), 32'h1);
      checkOutput("fixedBadLastCh", 32'(lastCh), 32'h2);
      applyStimulus(SI, 4'b0000, 4'b0000);
      pulseClear();
      checkOutput("fixedClrFlags", 32'(errFlags), 32'h0);
      applyStimulus(SI, 4'b0110, 4'b0000);
      applyStimulus(SI, 4'b0110, 4'b0010);
      checkOutput("fixedGoodFlags", 32'(errFlags), 32'h0);
      checkOutput("fixedGoodLastCh", 32'(lastCh), 32'h1);
      checkOutput("fixedGoodGrantCnt", 32'(grantCnt), 32'h2);
      applyStimulus(SI, 4'b0000, 4'b0000);

      // Rotating: after granting ch2 the search starts at ch3
      rotPrio = 1'b1;
      applyStimulus(SI, 4'b0100, 4'b0000);
      applyStimulus(SI, 4'b0100, 4'b0100);
      applyStimulus(SI, 4'b1001, 4'b0000);
      applyStimulus(SI, 4'b1001, 4'b1000);
      checkOutput("rotGoodFlags", 32'(errFlags), 32'h0);
      checkOutput("rotGoodLastCh", 32'(lastCh), 32'h3);
      checkOutput("rotGoodGrantCnt", 32'(grantCnt), 32'h4);
      applyStimulus(SI, 4'b0000, 4'b0000);
      applyStimulus(SI, 4'b0100, 4'b0000);
      applyStimulus(SI, 4'b0100, 4'b0100);
      applyStimulus(SI, 4'b1001, 4'b0000);
      applyStimulus(SI, 4'b1001, 4'b0001);
      checkOutput("rotBadFlags", 32'(errFlags), 32'h04);
      checkOutput("rotBadErrCnt", 32'(errCnt), 32'h1);
      checkOutput("rotBadLastCh", 32'(lastCh), 32'h0);
      checkOutput("rotBadGrantCnt", 32'(grantCnt), 32'h6);
      applyStimulus(SI, 4'b0000, 4'b0000);
      rotPrio = 1'b0;
      pulseClear();

      // Latency: ch3 waits with HLDA=1, timeout on the 16th cycle only
      for (int k = 1; k <= 15; k++) applyStimulus(SI, 4'b1000, 4'b0000);
      checkOutput("latBeforeFlags", 32'(errFlags), 32'h0);
      applyStimulus(SI, 4'b1000, 4'b0000);
      checkOutput("latFlags", 32'(errFlags), 32'h02);
      checkOutput("latErrCnt", 32'(errCnt), 32'h1);
      for (int k = 0; k < 10; k++) applyStimulus(SI, 4'b1000, 4'b0000);
      checkOutput("latHoldErrCnt", 32'(errCnt), 32'h1);
      applyStimulus(SI, 4'b0000, 4'b0000);
      pulseClear();

      // Deselected: bad DACK and illegal step are ignored
      csN = 1'b1;
      applyStimulus(S3, 4'b0000, 4'b0011);
      checkOutput("csIgnoreFlags", 32'(errFlags), 32'h0);
      applyStimulus(SI, 4'b0000, 4'b0000);
      csN = 1'b0;

      // Multi-bit DACK with HLDA low raises two flags but counts once
      hlda = 1'b0;
      applyStimulus(SI, 4'b0000, 4'b0011);
      checkOutput("dualFlags", 32'(errFlags), 32'h11);
      checkOutput("dualErrCnt", 32'(errCnt), 32'h1);
      hlda = 1'b1;

      // Reset mid-operation, then S1 is illegal because prev restarts at SI
      applyStimulus(S0, 4'b0000, 4'b0000);
      #2 rstN = 1'b0;
      #1;
      checkOutput("midResetFlags", 32'(errFlags), 32'h0);
      checkOutput("midResetErrCnt", 32'(errCnt), 32'h0);
      checkOutput("midResetGrantCnt", 32'(grantCnt), 32'h0);
      checkOutput("midResetBusy", 32'(busy), 32'h0);
      #2 rstN = 1'b1;
      applyStimulus(S1, 4'b0000, 4'b0000);
      checkOutput("postResetFlags", 32'(errFlags), 32'h08);
      checkOutput("postResetBusy", 32'(busy), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
